// File: rtl/led_pattern_gen.sv
// LED pattern generator: debounced MODE/PAUSE keys select and freeze one of four
// step patterns (rotate left/right, ping-pong, binary count) on a parametrised LED bank.
module led_pattern_gen #(
    parameter int N_LED      = 8,
    parameter int TICK_DIV   = 2_500_000,
    parameter int DEB_CYCLES = 250_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             ext_clk_25m,
    input  logic             ext_rst_n,
    input  logic             key_mode,
    input  logic             key_pause,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [N_LED-1:0] PAT_RST = N_LED'(1);
    localparam logic [N_LED-1:0] LED_RST = (ACTIVE_LOW != 0) ? ~PAT_RST : PAT_RST;

    // Bit 0 = MODE key, bit 1 = PAUSE key; 1 = released throughout.
    logic [1:0]          w_key_raw;
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0]          r_deb;
    logic [1:0]          r_deb_d;
    logic [1:0][DW-1:0]  r_deb_cnt;
    logic [1:0]          w_press;

    logic [PW-1:0]       r_presc;
    logic                r_paused;
    logic                r_dir_right;
    logic [1:0]          r_mode;
    logic [N_LED-1:0]    r_pat;
    logic [N_LED-1:0]    r_led;

    logic                w_mode_evt;
    logic                w_pause_evt;
    logic                w_tick;
    logic [PW-1:0]       w_presc_nxt;
    logic                w_dir_nxt;
    logic [1:0]          w_mode_nxt;
    logic [N_LED-1:0]    w_pat_nxt;
    logic [N_LED-1:0]    w_led_nxt;

    assign w_key_raw = {key_pause, key_mode};

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_deb     <= '1;
            r_deb_d   <= '1;
            r_deb_cnt <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Press pulse fires the cycle after the debounced level falls.
    assign w_press     = r_deb_d & ~r_deb;
    assign w_mode_evt  = w_press[0];
    assign w_pause_evt = w_press[1];

    assign w_tick = (r_presc == PW'(TICK_DIV - 1)) && !r_paused && !w_mode_evt;

    always_comb begin
        w_presc_nxt = r_presc;
        w_dir_nxt   = r_dir_right;
        w_mode_nxt  = r_mode;
        w_pat_nxt   = r_pat;
        if (w_mode_evt) begin
            w_mode_nxt  = r_mode + 2'd1;
            w_pat_nxt   = (w_mode_nxt == 2'd3) ? '0 : PAT_RST;
            w_dir_nxt   = 1'b0;
            w_presc_nxt = '0;
        end else if (!r_paused) begin
            w_presc_nxt = (r_presc == PW'(TICK_DIV - 1)) ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                case (r_mode)
                    2'd0: w_pat_nxt = {r_pat[N_LED-2:0], r_pat[N_LED-1]};
                    2'd1: w_pat_nxt = {r_pat[0], r_pat[N_LED-1:1]};
                    2'd2: begin
                        if (!r_dir_right) begin
                            w_pat_nxt = {r_pat[N_LED-2:0], 1'b0};
                            if (r_pat[N_LED-2]) w_dir_nxt = 1'b1;
                        end else begin
                            w_pat_nxt = {1'b0, r_pat[N_LED-1:1]};
                            if (r_pat[1]) w_dir_nxt = 1'b0;
                        end
                    end
                    default: w_pat_nxt = r_pat + N_LED'(1);
                endcase
            end
        end
        w_led_nxt = (ACTIVE_LOW != 0) ? ~w_pat_nxt : w_pat_nxt;
    end

    always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_presc     <= '0;
            r_paused    <= 1'b0;
            r_dir_right <= 1'b0;
            r_mode      <= 2'd0;
            r_pat       <= PAT_RST;
            r_led       <= LED_RST;
        end else begin
            r_presc     <= w_presc_nxt;
            r_paused    <= r_paused ^ w_pause_evt;
            r_dir_right <= w_dir_nxt;
            r_mode      <= w_mode_nxt;
            r_pat       <= w_pat_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    assign tick = w_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: randomized key timing against a
// step-count reference model of the pattern, prescaler and key conditioning.
module tb_led_pattern_gen;

    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int DEB = 8;
    localparam int AL  = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_mode = 1'b1;
    logic         key_pause = 1'b1;
    logic [N-1:0] led;
    logic [1:0]   mode;
    logic         tick;

    int checks = 0;
    int failures = 0;

    // Reference model: pattern is a pure function of (mode, steps since reload).
    int m_mode, m_k, m_active;
    bit m_paused, m_tick;
    bit m_deb [2];
    bit m_evt [2];
    bit hist  [2][DEB+2];

    led_pattern_gen #(.N_LED(N), .TICK_DIV(TD), .DEB_CYCLES(DEB), .ACTIVE_LOW(AL)) dut (
        .ext_clk_25m(clk),
        .ext_rst_n  (rst_n),
        .key_mode   (key_mode),
        .key_pause  (key_pause),
        .led        (led),
        .mode       (mode),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    function automatic logic [N-1:0] model_pat(int md, int k);
        logic [N-1:0] one;
        int p;
        one = N'(1);
        case (md)
            0: return one << (k % N);
            1: return one << ((N - (k % N)) % N);
            2: begin
                p = k % (2 * N - 2);
                if (p >= N) p = 2 * N - 2 - p;
                return one << p;
            end
            default: return N'(k % (1 << N));
        endcase
    endfunction

    function automatic logic [N-1:0] exp_led();
        logic [N-1:0] p;
        p = model_pat(m_mode, m_k);
        return (AL != 0) ? ~p : p;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_active = 0; m_paused = 0; m_tick = 0;
        for (int i = 0; i < 2; i++) begin
            m_deb[i] = 1'b1;
            m_evt[i] = 1'b0;
            for (int j = 0; j < DEB + 2; j++) hist[i][j] = 1'b1;
        end
    endtask

    // One clock edge: apply the events of the cycle that just ended, then derive
    // the key events and tick of the cycle that starts now. Returns 1 ns after the edge.
    task automatic clk_cycle();
        bit raw [2];
        bit all_diff;
        @(posedge clk);
        raw[0] = key_mode;
        raw[1] = key_pause;
        if (m_evt[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_k = 0;
            m_active = 0;
        end else if (!m_paused) begin
            if (m_tick) m_k++;
            m_active++;
        end
        if (m_evt[1]) m_paused = !m_paused;
        for (int i = 0; i < 2; i++) begin
            for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
            m_evt[i] = 1'b0;
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) if (hist[i][j] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_deb[i] = !m_deb[i];
                m_evt[i] = (m_deb[i] == 1'b0);
            end
        end
        m_tick = !m_paused && (m_active % TD == TD - 1) && !m_evt[0];
        #1;
    endtask

    task automatic test_reset();
        key_mode = 1'b1;
        key_pause = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if (led !== 4'b1110) begin failures++; $display("FAIL reset_led got=%b exp=1110", led); end
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotate_left();
        logic [N-1:0] want [int];
        want[4] = 4'b1101; want[8] = 4'b1011; want[12] = 4'b0111; want[16] = 4'b1110;
        for (int c = 1; c <= 24; c++) begin
            clk_cycle();
            if (want.exists(c)) begin
                checks++;
                if (led !== want[c]) begin failures++; $display("FAIL rotl_const c=%0d got=%b exp=%b", c, led, want[c]); end
            end
            checks++;
            if (tick !== ((c % TD) == TD - 1)) begin failures++; $display("FAIL rotl_tick c=%0d got=%b", c, tick); end
            checks++;
            if (led !== exp_led()) begin failures++; $display("FAIL rotl_led c=%0d got=%b exp=%b", c, led, exp_led()); end
            checks++;
            if (mode !== 2'd0) begin failures++; $display("FAIL rotl_mode c=%0d got=%0d exp=0", c, mode); end
        end
    endtask

    task automatic test_mode_cycle();
        int hold, gap, lat, prev;
        for (int p = 0; p < 4; p++) begin
            hold = $urandom_range(DEB + 2, 20);
            gap  = $urandom_range(70, 90);
            prev = m_mode;
            lat  = -1;
            for (int c = 0; c < hold + gap; c++) begin
                key_mode = (c < hold) ? 1'b0 : 1'b1;
                clk_cycle();
                if (lat < 0 && mode !== 2'(prev)) begin
                    lat = c + 1;
                    checks++;
                    if (led !== (((prev + 1) % 4 == 3) ? 4'b1111 : 4'b1110)) begin
                        failures++; $display("FAIL mode_reload p=%0d got=%b", p, led);
                    end
                end
                checks++;
                if (led !== exp_led()) begin failures++; $display("FAIL mcyc_led p=%0d c=%0d got=%b exp=%b", p, c, led, exp_led()); end
                checks++;
                if (tick !== m_tick) begin failures++; $display("FAIL mcyc_tick p=%0d c=%0d got=%b exp=%b", p, c, tick, m_tick); end
                checks++;
                if (mode !== 2'(m_mode)) begin failures++; $display("FAIL mcyc_mode p=%0d c=%0d got=%0d exp=%0d", p, c, mode, m_mode); end
            end
            checks++;
            if (lat < DEB + 2 || lat > DEB + 4) begin failures++; $display("FAIL mode_latency p=%0d got=%0d exp=%0d..%0d", p, lat, DEB + 2, DEB + 4); end
        end
    endtask

    task automatic test_glitch();
        int len, start_mode;
        bit which;
        start_mode = m_mode;
        for (int g = 0; g < 8; g++) begin
            len   = (g == 0) ? 5 : $urandom_range(1, DEB - 1);
            which = (g == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            for (int c = 0; c < len + DEB + 4; c++) begin
                key_mode  = (!which && c < len) ? 1'b0 : 1'b1;
                key_pause = ( which && c < len) ? 1'b0 : 1'b1;
                clk_cycle();
                checks++;
                if (led !== exp_led()) begin failures++; $display("FAIL glitch_led g=%0d c=%0d got=%b exp=%b", g, c, led, exp_led()); end
                checks++;
                if (tick !== ((m_active % TD) == TD - 1)) begin failures++; $display("FAIL glitch_tick g=%0d c=%0d got=%b", g, c, tick); end
            end
        end
        checks++;
        if (mode !== 2'(start_mode)) begin failures++; $display("FAIL glitch_mode got=%0d exp=%0d", mode, start_mode); end
    endtask

    task automatic test_pause();
        logic [N-1:0] frozen;
        int frozen_cnt;
        frozen_cnt = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 20 + (ph == 0 ? 40 : 0) + $urandom_range(20, 30); c++) begin
                key_pause = (c < 20) ? 1'b0 : 1'b1;
                clk_cycle();
                if (m_paused) begin
                    if (frozen_cnt == 0) frozen = exp_led();
                    frozen_cnt++;
                    checks++;
                    if (tick !== 1'b0) begin failures++; $display("FAIL pause_tick c=%0d got=%b exp=0", c, tick); end
                    checks++;
                    if (led !== frozen) begin failures++; $display("FAIL pause_frozen c=%0d got=%b exp=%b", c, led, frozen); end
                end
                checks++;
                if (led !== exp_led()) begin failures++; $display("FAIL pause_led ph=%0d c=%0d got=%b exp=%b", ph, c, led, exp_led()); end
                checks++;
                if (tick !== m_tick) begin failures++; $display("FAIL pause_model_tick ph=%0d c=%0d got=%b exp=%b", ph, c, tick, m_tick); end
            end
        end
        checks++;
        if (frozen_cnt < 40) begin failures++; $display("FAIL pause_span got=%0d exp>=40", frozen_cnt); end
    endtask

    task automatic test_tick_collision();
        int tgt;
        bit seen, evt_prev;
        tgt = (((TD - 1 - (DEB + 2)) % TD) + TD) % TD;
        for (int i = 0; i < 4 * TD && ((m_active % TD) != tgt || m_paused); i++) clk_cycle();
        checks++;
        if ((m_active % TD) != tgt || m_paused) begin failures++; $display("FAIL collision_align got=%0d exp=%0d", m_active % TD, tgt); end
        seen = 0;
        evt_prev = 0;
        for (int c = 0; c < 40; c++) begin
            key_mode = (c < 20) ? 1'b0 : 1'b1;
            clk_cycle();
            if (evt_prev) begin
                checks++;
                if (led !== 4'b1110 || mode !== 2'd1) begin failures++; $display("FAIL collision_reload got=%b/%0d exp=1110/1", led, mode); end
            end
            evt_prev = m_evt[0];
            if (m_evt[0]) begin
                seen = 1;
                checks++;
                if (tick !== 1'b0) begin failures++; $display("FAIL collision_tick got=%b exp=0", tick); end
            end
            checks++;
            if (led !== exp_led()) begin failures++; $display("FAIL coll_led c=%0d got=%b exp=%b", c, led, exp_led()); end
            checks++;
            if (tick !== m_tick) begin failures++; $display("FAIL coll_mtick c=%0d got=%b exp=%b", c, tick, m_tick); end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL collision_event got=0 exp=1"); end
    endtask

    task automatic test_simultaneous();
        // Both keys together: mode 1 -> 2 and pause; then resume, then pause mid ping-pong.
        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 20 + $urandom_range(25, 45); c++) begin
                key_mode  = (ph == 0 && c < 20) ? 1'b0 : 1'b1;
                key_pause = (c < 20) ? 1'b0 : 1'b1;
                clk_cycle();
                checks++;
                if (led !== exp_led()) begin failures++; $display("FAIL simul_led ph=%0d c=%0d got=%b exp=%b", ph, c, led, exp_led()); end
                checks++;
                if (tick !== m_tick) begin failures++; $display("FAIL simul_tick ph=%0d c=%0d got=%b exp=%b", ph, c, tick, m_tick); end
                checks++;
                if (mode !== 2'(m_mode)) begin failures++; $display("FAIL simul_mode ph=%0d c=%0d got=%0d exp=%0d", ph, c, mode, m_mode); end
            end
        end
        checks++;
        if (mode !== 2'd2 || !m_paused) begin failures++; $display("FAIL simul_state got=%0d exp=2 paused", mode); end
    endtask

    task automatic test_reset_midop();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 4'b1110) begin failures++; $display("FAIL midrst_led got=%b exp=1110", led); end
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL midrst_mode got=%0d exp=0", mode); end
        checks++;
        if (tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", tick); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            clk_cycle();
            if (c == 4) begin
                checks++;
                if (led !== 4'b1101) begin failures++; $display("FAIL midrst_restart got=%b exp=1101", led); end
            end
            checks++;
            if (led !== exp_led()) begin failures++; $display("FAIL midrst_run c=%0d got=%b exp=%b", c, led, exp_led()); end
            checks++;
            if (tick !== ((c % TD) == TD - 1)) begin failures++; $display("FAIL midrst_tick_run c=%0d got=%b", c, tick); end
        end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_mode_cycle();
        test_glitch();
        test_pause();
        test_tick_collision();
        test_simultaneous();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
